// File: rtl/caliptra_prim_arbiter_burst_rr.sv
// caliptra_prim_arbiter_burst_rr: N:1 round-robin arbiter that locks the grant for a multi-beat burst.
// Optional CALIPTRA_PRIM_ARB_BURST_TRUNC_CNT_EN adds trunc_cnt_o, a saturating count of cap-truncated bursts.
`default_nettype none

module caliptra_prim_arbiter_burst_rr #(
  parameter int N        = 4,
  parameter int DW       = 32,
  parameter int MaxBurst = 16,
  localparam int IdxW    = $clog2(N),
  localparam int CntW    = $clog2(MaxBurst + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0]        last_i,
  input  logic [DW-1:0]       data_i [N],
  output logic [N-1:0]        gnt_o,
  output logic [IdxW-1:0]     idx_o,
  output logic                valid_o,
  output logic [DW-1:0]       data_o,
  output logic                last_o,
  input  logic                ready_i,
  output logic                locked_o,
`ifdef CALIPTRA_PRIM_ARB_BURST_TRUNC_CNT_EN
  output logic [15:0]         trunc_cnt_o,
`endif
  output logic [CntW-1:0]     beat_cnt_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [CntW-1:0] CapCnt = CntW'(MaxBurst - 1);

  state_e            state, state_d;
  logic [N-1:0]      mask, mask_d;
  logic [IdxW-1:0]   lock_idx, lock_d;
  logic [CntW-1:0]   beat_cnt, cnt_d;

  logic [N-1:0]      masked_req;
  logic [N-1:0]      arb_req;
  logic [N-1:0]      ppc;
  logic [N-1:0]      above;
  logic [IdxW-1:0]   winner;
  logic              is_burst;
  logic              forced_last;
  logic              accept;

  // Fall back to the unmasked requests once every requester above the pointer is idle.
  always_comb begin
    masked_req = mask & req_i;
    arb_req    = (|masked_req) ? masked_req : req_i;
    winner     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (arb_req[i]) winner = IdxW'(i);
    end
    ppc = '0;
    ppc[0] = arb_req[0];
    for (int i = 1; i < N; i++) begin
      ppc[i] = ppc[i-1] | arb_req[i];
    end
  end

  always_comb begin
    is_burst    = (state == BURST);
    idx_o       = is_burst ? lock_idx : winner;
    valid_o     = is_burst ? req_i[lock_idx] : (|req_i);
    data_o      = data_i[idx_o];
    forced_last = is_burst ? (beat_cnt == CapCnt) : (MaxBurst == 1);
    last_o      = last_i[idx_o] | forced_last;
    accept      = valid_o & ready_i;
    gnt_o       = '0;
    if (accept && !rst_i) gnt_o[idx_o] = 1'b1;
  end

  always_comb begin
    above = '0;
    for (int i = 0; i < N; i++) begin
      above[i] = (i > int'(idx_o));
    end
  end

  always_comb begin
    state_d = state;
    mask_d  = mask;
    lock_d  = lock_idx;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        if (valid_o) begin
          if (!ready_i) begin
            // Hold the decision so a stalled winner is not overtaken.
            mask_d = ppc;
          end else if (last_o) begin
            mask_d = above;
          end else begin
            lock_d  = winner;
            cnt_d   = CntW'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (last_o) begin
            mask_d  = above;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = beat_cnt + CntW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mask     <= '0;
      lock_idx <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      mask     <= mask_d;
      lock_idx <= lock_d;
      beat_cnt <= cnt_d;
    end
  end

  assign locked_o   = is_burst;
  assign beat_cnt_o = beat_cnt;

`ifdef CALIPTRA_PRIM_ARB_BURST_TRUNC_CNT_EN
  logic [15:0] trunc_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trunc_cnt <= '0;
    end else if (accept && forced_last && !last_i[idx_o] && (trunc_cnt != 16'hFFFF)) begin
      trunc_cnt <= trunc_cnt + 16'd1;
    end
  end

  assign trunc_cnt_o = trunc_cnt;
`endif

`ifndef SYNTHESIS
  logic            held_vld;
  logic [IdxW-1:0] held_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_vld <= 1'b0;
      held_idx <= '0;
    end else begin
      held_vld <= ~is_burst & valid_o & ~ready_i;
      held_idx <= idx_o;
      assert ($onehot0(gnt_o));
      assert (!(|gnt_o) || (ready_i && valid_o));
      assert (!is_burst || ((gnt_o & ~(N'(1) << lock_idx)) == '0));
      if (held_vld && !is_burst && req_i[held_idx]) assert (idx_o == held_idx);
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/caliptra_prim_arbiter_burst_rr.md
Name: caliptra_prim_arbiter_burst_rr

Overview:
- N:1 round-robin arbiter with burst locking, for shared-sink paths where a requester sends a multi-beat transfer (e.g. a mailbox or DMA write stream).
- Once a requester wins, the grant is locked to it until its last beat is accepted or a MaxBurst beat cap forces release.
- Arbitration between bursts uses the mask-based, prefix-OR round-robin scheme used by the existing arbiters.
- Sits between N valid/ready producers and one valid/ready sink.

Parameters:
- N, 4, number of requesters; legal range ≥ 2.
- DW, 32, data width per beat.
- MaxBurst, 16, maximum beats per locked burst; legal range ≥ 1.
- IdxW, $clog2(N), derived (localparam), grant index width.
- CntW, $clog2(MaxBurst+1), derived (localparam), beat counter width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- req_i  input  N  per-requester beat valid.
- last_i  input  N  per-requester "this beat ends the burst".
- data_i  input  DW x N  per-requester beat data (unpacked array [N]).
- gnt_o  output  N  one-hot0 beat accept, one per requester.
- idx_o  output  IdxW  index of the current or selected requester.
- valid_o  output  1  beat valid to the sink.
- data_o  output  DW  muxed beat data.
- last_o  output  1  beat ends the burst; includes forced end at the cap.
- ready_i  input  1  sink ready.
- locked_o  output  1  high while in the BURST state.
- beat_cnt_o  output  CntW  number of beats accepted in the current burst.

Behaviour:
- Reset values (rst_i high): state=IDLE, mask='0, lock_idx='0, beat_cnt='0.
  - Outputs: gnt_o=0, locked_o=0, beat_cnt_o=0.
  - valid_o, data_o, idx_o, last_o are combinational from inputs, so they follow req_i.
- All arbitration is combinational: zero-cycle latency from req_i to valid_o.
- Beat transfer condition: a beat is accepted in a cycle where valid_o && ready_i.
- IDLE state:
  - arb_req = (mask&req_i) != 0 ? mask&req_i : req_i.
  - Winner = lowest set bit of arb_req; idx_o = winner index.
  - valid_o = |req_i.
  - data_o = data_i[idx_o]; last_o = last_i[idx_o] | (MaxBurst==1).
  - gnt_o = ready_i ? onehot(winner) : 0.
- IDLE, valid && !ready:
  - Decision is held: mask <= prefix-OR of arb_req, so the same winner is chosen next cycle if its request stays high.
- IDLE, beat accepted with last_o=1 (single-beat burst):
  - mask <= bits strictly above the winner; stay in IDLE; beat_cnt stays 0.
- IDLE, beat accepted with last_o=0:
  - lock_idx <= winner; beat_cnt <= 1; go to BURST.
- BURST state:
  - idx_o = lock_idx; valid_o = req_i[lock_idx]; data_o = data_i[lock_idx].
  - gnt_o[lock_idx] = valid_o && ready_i; all other requesters get no grant, whatever their req_i.
- Forced last in BURST: last_o = last_i[lock_idx] | (beat_cnt == MaxBurst-1).
- BURST, beat accepted with last_o=0: beat_cnt++.
- BURST, beat accepted with last_o=1:
  - go to IDLE; beat_cnt <= 0.
  - mask <= bits strictly above lock_idx; this also applies when lock_idx = N-1, where mask becomes 0.
- BURST, req_i[lock_idx] low: valid_o=0 and the lock is held with no timeout. Inter-beat gaps are legal.
- BURST, ready_i low: no state change.
- Simultaneous events: requests from other requesters during BURST are ignored and served only after release, in round-robin order starting after lock_idx.
- beat_cnt never exceeds MaxBurst-1 in state; beat_cnt_o mirrors the register.
- Reset mid-burst: immediate return to IDLE with the mask cleared. A partially sent burst is not resumed.
- Assertions:
  - gnt_o is onehot0.
  - gnt_o implies ready_i and valid_o.
  - in BURST, gnt_o & ~(1<<lock_idx) == 0.
  - a held IDLE decision keeps idx_o stable while !ready_i and the winner's request stays high.

Optional Feature:
- Macro: CALIPTRA_PRIM_ARB_BURST_TRUNC_CNT_EN.
- When defined:
  - adds output trunc_cnt_o [15:0], a saturating count of bursts ended by the MaxBurst cap rather than by last_i.
  - increments on an accepted beat where forced-last is true and last_i[lock_idx] is 0.
  - saturates at 16'hFFFF; resets to 0.
- When not defined: the port and counter are absent; truncation behaviour is otherwise identical.

Test Plan:
- Single beats, N=4, req_i=4'b1111, last_i=4'b1111, ready_i=1 for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,0010,0100,1000; locked_o stays 0.
- Locked burst: req_i=4'b0011; requester 0 sends 3 beats with last on beat 3 -> gnt_o=0001 for 3 cycles with requester 1 starved, locked_o=1 for cycles 2–3, then gnt_o=0010.
- Cap: MaxBurst=4; requester 2 holds req with last_i=0 -> 4 beats granted, last_o=1 on beat 4, return to IDLE; trunc_cnt_o=1 when the macro is defined.
- Backpressure: ready_i=0 for 5 cycles with req_i=4'b0110 and mask pointing past requester 1 -> idx_o=2 held stable for all 5 cycles, gnt_o=0; ready_i=1 -> gnt_o=0100.
- Gap and reset: mid-burst req_i[lock_idx]=0 for 3 cycles -> valid_o=0 and locked_o held; then assert rst_i -> locked_o=0, beat_cnt_o=0, and the next arbitration starts from requester 0.
